saturn_mouse_acc: RTL and testbench
===================================

// Module: saturn_mouse_acc
// PURPOSE
//  Upstream stage of the pad port encoder. Turns raw HPS PS/2 mouse packets into the Saturn Shuttle Mouse
//  report: flags, buttons and 8-bit X/Y, delivered as per-axis sums of motion since the last Saturn read.
//  Consumer clears the sums when a read completes (STATE==10 on a PAD_MOUSE port).
// PARAMETERS
//  ACC_W       10  signed accumulator width per axis (>=10)
//  SENS_SHIFT  0   arithmetic right shift applied to each incoming 9-bit packet delta (0..3)
// PORTS
//  CLK          in   1   system clock
//  RST          in   1   asynchronous, active-high reset
//  CE           in   1   SMPC clock enable; all state updates qualified by CE
//  RESET_ACC    in   1   level; clear request from port encoder (held several CE)
//  READ_ACTIVE  in   1   port encoder mid-read (STATE!=0); used only with SATURN_MOUSE_SNAPSHOT_EN
//  MOUSE        in   25  [24] packet toggle, [7:0] status, [15:8] dX low, [23:16] dY low
//  MOUSE_EXT    in   16  [15:8] extra buttons (bit 12 = button 4 -> START), [7:0] wheel (ignored)
//  FLAGS        out  4   {Yovf,Xovf,Ysign,Xsign}
//  BUTTONS      out  4   {START,MID,RIGHT,LEFT}, active-high
//  X            out  8   low byte of saturated X delta
//  Y            out  8   low byte of saturated Y delta
// BEHAVIOUR
//  - Reset: accumulators 0, toggle_q <= MOUSE[24] sampled at reset release, clr_q 0; outputs FLAGS=0,
//    BUTTONS=0, X=0, Y=0.
//  - Packet detect: on CE, MOUSE[24]!=toggle_q => new packet; toggle_q<=MOUSE[24]. Detection is a compare,
//    not an edge, so packets arriving while CE=0 are taken on the next CE. One packet per CE max.
//  - Delta: d = {status[4],dX} (9-bit signed) >>> SENS_SHIFT; same for Y with status[5]. If status[6]/[7]
//    (PS/2 overflow) is set, that axis's delta is forced to +/-255 using its sign bit.
//  - Accumulate: acc <= sat(acc + d) into ACC_W signed range; no wrap-around ever.
//  - Clear: rising edge of RESET_ACC (clr_q tracks level) zeroes both accumulators once. Held level has no
//    further effect. Same-CE clear + packet: acc <= sat(0 + d), so the new motion is kept for the next read.
//  - Output map (registered, 1 CE after the accumulator update): o = clamp(acc, -256..255). X = o[7:0],
//    Xsign = o[8], Xovf = 1 iff acc outside -256..255 (clamped). Same for Y.
//  - Buttons: latched from every packet: LEFT=status[0], RIGHT=status[1], MID=status[2],
//    START=MOUSE_EXT[12]. Not cleared by RESET_ACC.
//  - status[3] (always-1 sync bit) ignored; no packet validation.
//  - RST mid-packet or mid-read: everything returns to reset values immediately; no pending state kept.
// CONFIGURATION
//  SATURN_MOUSE_SNAPSHOT_EN defined: output registers update only on CE with READ_ACTIVE=0, so one
//    Saturn read never sees a torn X/Y/flag set. Accumulation and clear continue while frozen.
//  Not defined: outputs update every CE; READ_ACTIVE is ignored.
// STRUCTURE
//  saturn_mouse_pkg: status bit indices (L,R,M,SYNC,XS,YS,XO,YO), FLAGS bit indices, EXT_START_BIT=12,
//    typedef mouse_report_t {flags,buttons,x,y}.
//  Sub-module mouse_axis_acc (instantiated twice): delta form, overflow force, shift, saturating add, clear,
//    clamp to 9 bits + ovf. Top: toggle/clear detect, button latch, output/snapshot registers.
// TESTING
//  1 One packet dX=+5 (dY=-3) -> X=8'h05 Xsign=0, Y=8'hFD Ysign=1, FLAGS=4'b0010.
//  2 Three packets dX=+100 -> acc 300, X=8'hFF Xsign=0 Xovf=1; RESET_ACC pulse -> X=0, FLAGS=0.
//  3 RESET_ACC held 20 CE, packet dX=+7 arrives on CE 10 -> X=8'h07 after (single clear on edge only).
//  4 Packet and RESET_ACC rising on same CE, dX=-2 -> X=8'hFE Xsign=1 (packet survives the clear).
//  5 2000 packets dX=-255 -> acc pinned at -2^(ACC_W-1), X=8'h00 Xsign=1 Xovf=1; no wrap positive.
//  6 SNAPSHOT_EN: READ_ACTIVE=1, packet dX=+9 -> X unchanged; READ_ACTIVE=0 -> X=8'h09 next CE.
//    Also status=8'h0B with MOUSE_EXT[12]=1 -> BUTTONS=4'b1011.

Source files
------------

// File: rtl/saturn_mouse_pkg.sv
// rtl/saturn_mouse_pkg.sv - PS/2 status bit map, FLAGS bit map and report type for the Saturn mouse path
package saturn_mouse_pkg;

   localparam int ST_L    = 0;
   localparam int ST_R    = 1;
   localparam int ST_M    = 2;
   localparam int ST_SYNC = 3;
   localparam int ST_XS   = 4;
   localparam int ST_YS   = 5;
   localparam int ST_XO   = 6;
   localparam int ST_YO   = 7;

   localparam int FL_XSIGN = 0;
   localparam int FL_YSIGN = 1;
   localparam int FL_XOVF  = 2;
   localparam int FL_YOVF  = 3;

   localparam int EXT_START_BIT = 12;

   typedef struct packed {
      logic [3:0] flags;
      logic [3:0] buttons;
      logic [7:0] x;
      logic [7:0] y;
   } mouse_report_t;

endpackage

// File: rtl/mouse_axis_acc.sv
// rtl/mouse_axis_acc.sv - one axis: packet delta, saturating accumulate, clear, clamp to 9-bit report
module mouse_axis_acc #(
   parameter int ACC_W      = 10,
   parameter int SENS_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic       pkt,
   input  logic       clr,
   input  logic [7:0] delta_lo,
   input  logic       delta_sign,
   input  logic       delta_ovf,
   output logic [8:0] clamp_o,
   output logic       clamp_ovf
);

   localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-256);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [8:0]       raw, delta;
   logic signed [ACC_W:0]   base, sum;

   always_comb begin
      raw = {delta_sign, delta_lo};
      // PS/2 overflow means the true motion is unknown; report full scale in its direction
      if (delta_ovf) delta = delta_sign ? -9'sd255 : 9'sd255;
      else           delta = raw >>> SENS_SHIFT;

      base = clr ? '0 : {acc_q[ACC_W-1], acc_q};
      sum  = base + {{(ACC_W-8){delta[8]}}, delta};

      acc_d = acc_q;
      if (ce) begin
         if (pkt) begin
            if (sum > SUM_MAX)      acc_d = SUM_MAX[ACC_W-1:0];
            else if (sum < SUM_MIN) acc_d = SUM_MIN[ACC_W-1:0];
            else                    acc_d = sum[ACC_W-1:0];
         end else if (clr) begin
            acc_d = '0;
         end
      end

      clamp_ovf = 1'b1;
      if (acc_q > OUT_MAX)      clamp_o = 9'h0FF;
      else if (acc_q < OUT_MIN) clamp_o = 9'h100;
      else begin
         clamp_o   = acc_q[8:0];
         clamp_ovf = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

endmodule

// File: rtl/saturn_mouse_acc.sv
// rtl/saturn_mouse_acc.sv - PS/2 packets to Saturn Shuttle Mouse report; SATURN_MOUSE_SNAPSHOT_EN freezes
// outputs while a Saturn read is in progress
module saturn_mouse_acc
   import saturn_mouse_pkg::*;
#(
   parameter int ACC_W      = 10,
   parameter int SENS_SHIFT = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic        RESET_ACC,
   input  logic        READ_ACTIVE,
   input  logic [24:0] MOUSE,
   input  logic [15:0] MOUSE_EXT,
   output logic [3:0]  FLAGS,
   output logic [3:0]  BUTTONS,
   output logic [7:0]  X,
   output logic [7:0]  Y
);

   logic          init_q, init_d;
   logic          toggle_q, toggle_d;
   logic          clr_q, clr_d;
   logic [3:0]    buttons_q, buttons_d;
   mouse_report_t rpt_q, rpt_d;
   logic          pkt, clr_edge, rpt_upd;
   logic [8:0]    x_o, y_o;
   logic          x_ovf, y_ovf;
   logic [15:0]   unused_bits;

   assign unused_bits = {MOUSE_EXT[15:13], MOUSE_EXT[11:0], MOUSE[ST_SYNC]};

`ifdef SATURN_MOUSE_SNAPSHOT_EN
   assign rpt_upd = CE & ~READ_ACTIVE;
`else
   logic unused_read_active;
   assign unused_read_active = READ_ACTIVE;
   assign rpt_upd = CE;
`endif

   mouse_axis_acc #(.ACC_W(ACC_W), .SENS_SHIFT(SENS_SHIFT)) u_x (
      .clk(CLK), .rst(RST), .ce(CE), .pkt(pkt), .clr(clr_edge),
      .delta_lo(MOUSE[15:8]), .delta_sign(MOUSE[ST_XS]), .delta_ovf(MOUSE[ST_XO]),
      .clamp_o(x_o), .clamp_ovf(x_ovf)
   );

   mouse_axis_acc #(.ACC_W(ACC_W), .SENS_SHIFT(SENS_SHIFT)) u_y (
      .clk(CLK), .rst(RST), .ce(CE), .pkt(pkt), .clr(clr_edge),
      .delta_lo(MOUSE[23:16]), .delta_sign(MOUSE[ST_YS]), .delta_ovf(MOUSE[ST_YO]),
      .clamp_o(y_o), .clamp_ovf(y_ovf)
   );

   always_comb begin
      // The first clock after reset adopts the current toggle so a stale level is not taken as a packet
      pkt      = CE & ~init_q & (MOUSE[24] != toggle_q);
      clr_edge = CE & RESET_ACC & ~clr_q;
      init_d   = 1'b0;
      toggle_d = (init_q | CE) ? MOUSE[24] : toggle_q;
      clr_d    = CE ? RESET_ACC : clr_q;

      buttons_d = buttons_q;
      if (pkt) buttons_d = {MOUSE_EXT[EXT_START_BIT], MOUSE[ST_M], MOUSE[ST_R], MOUSE[ST_L]};

      rpt_d = rpt_q;
      if (rpt_upd) begin
         rpt_d.flags[FL_XSIGN] = x_o[8];
         rpt_d.flags[FL_YSIGN] = y_o[8];
         rpt_d.flags[FL_XOVF]  = x_ovf;
         rpt_d.flags[FL_YOVF]  = y_ovf;
         rpt_d.buttons         = buttons_q;
         rpt_d.x               = x_o[7:0];
         rpt_d.y               = y_o[7:0];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         init_q    <= 1'b1;
         toggle_q  <= 1'b0;
         clr_q     <= 1'b0;
         buttons_q <= '0;
         rpt_q     <= '0;
      end else begin
         init_q    <= init_d;
         toggle_q  <= toggle_d;
         clr_q     <= clr_d;
         buttons_q <= buttons_d;
         rpt_q     <= rpt_d;
      end
   end

   assign FLAGS   = rpt_q.flags;
   assign BUTTONS = rpt_q.buttons;
   assign X       = rpt_q.x;
   assign Y       = rpt_q.y;

endmodule

// File: tb/tb_saturn_mouse_acc.sv
// tb/tb_saturn_mouse_acc.sv - directed and randomized checks of saturn_mouse_acc against an integer model
module tb_saturn_mouse_acc;

   localparam int ACC_W      = 10;
   localparam int SENS_SHIFT = 0;
   localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;
   localparam int ACC_MIN    = -(1 << (ACC_W - 1));

   logic        CLK, RST, CE, RESET_ACC, READ_ACTIVE;
   logic [24:0] MOUSE;
   logic [15:0] MOUSE_EXT;
   logic [3:0]  FLAGS, BUTTONS;
   logic [7:0]  X, Y;

   saturn_mouse_acc #(.ACC_W(ACC_W), .SENS_SHIFT(SENS_SHIFT)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .RESET_ACC(RESET_ACC), .READ_ACTIVE(READ_ACTIVE),
      .MOUSE(MOUSE), .MOUSE_EXT(MOUSE_EXT),
      .FLAGS(FLAGS), .BUTTONS(BUTTONS), .X(X), .Y(Y)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, plain integers
   int          acc_x, acc_y;
   logic [3:0]  btn_m;
   logic        tog_m, clr_m;
   logic [23:0] out_m;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v > ACC_MAX) return ACC_MAX;
      if (v < ACC_MIN) return ACC_MIN;
      return v;
   endfunction

   function automatic int pkt_delta(input logic [7:0] lo, input logic s, input logic o);
      int v;
      if (o) return s ? -255 : 255;
      v = s ? int'(lo) - 256 : int'(lo);
      return v >>> SENS_SHIFT;
   endfunction

   function automatic logic [9:0] axis_out(input int a);
      int o;
      logic [8:0] t;
      o = (a > 255) ? 255 : ((a < -256) ? -256 : a);
      t = 9'(o);
      return {(o != a), t};
   endfunction

   function automatic logic [23:0] report(input int ax, input int ay, input logic [3:0] b);
      logic [9:0] xo, yo;
      xo = axis_out(ax);
      yo = axis_out(ay);
      return {yo[9], xo[9], yo[8], xo[8], b, xo[7:0], yo[7:0]};
   endfunction

   function automatic logic [23:0] outs();
      return {FLAGS, BUTTONS, X, Y};
   endfunction

   task automatic step(input logic ce, input logic ra, input logic rd);
      logic pkt, clr_e, snap_ok;
      CE = ce;
      RESET_ACC = ra;
      READ_ACTIVE = rd;
      @(posedge CLK);
`ifdef SATURN_MOUSE_SNAPSHOT_EN
      snap_ok = !rd;
`else
      snap_ok = 1'b1;
`endif
      if (ce) begin
         if (snap_ok) out_m = report(acc_x, acc_y, btn_m);
         pkt   = (MOUSE[24] != tog_m);
         clr_e = ra && !clr_m;
         if (clr_e) begin
            acc_x = 0;
            acc_y = 0;
         end
         if (pkt) begin
            acc_x = sat(acc_x + pkt_delta(MOUSE[15:8], MOUSE[4], MOUSE[6]));
            acc_y = sat(acc_y + pkt_delta(MOUSE[23:16], MOUSE[5], MOUSE[7]));
            btn_m = {MOUSE_EXT[12], MOUSE[2:0]};
         end
         tog_m = MOUSE[24];
         clr_m = ra;
      end
      #1;
      check("model", outs(), out_m);
   endtask

   task automatic load_pkt(input int dx, input int dy, input logic [2:0] b, input logic start,
                           input logic xo, input logic yo);
      logic [8:0] dx9, dy9;
      dx9 = 9'(dx);
      dy9 = 9'(dy);
      MOUSE     = {~MOUSE[24], dy9[7:0], dx9[7:0], yo, xo, dy9[8], dx9[8], 1'b1, b};
      MOUSE_EXT = {3'b000, start, 12'h000};
   endtask

   task automatic send(input int dx, input int dy);
      load_pkt(dx, dy, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      CE = 1'b0;
      RESET_ACC = 1'b0;
      READ_ACTIVE = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_out", outs(), 24'h0);
      acc_x = 0;
      acc_y = 0;
      btn_m = 4'h0;
      clr_m = 1'b0;
      tog_m = MOUSE[24];
      out_m = 24'h0;
      RST = 1'b0;
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      RST = 1'b1;
      CE = 1'b0;
      RESET_ACC = 1'b0;
      READ_ACTIVE = 1'b0;
      MOUSE = 25'h1000008;
      MOUSE_EXT = 16'h0;
      do_reset();

      // single packet, mixed signs
      send(5, -3);
      step(1'b1, 1'b0, 1'b0);
      check("t1_x", 24'(X), 24'(8'h05));
      check("t1_y", 24'(Y), 24'(8'hFD));
      check("t1_flags", 24'(FLAGS), 24'(4'b0010));

      // accumulation beyond the 9-bit report, then a clear pulse
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (3) send(100, 0);
      step(1'b1, 1'b0, 1'b0);
      check("t2_x_sat", 24'(X), 24'(8'hFF));
      check("t2_flags_sat", 24'(FLAGS), 24'(4'b0100));
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t2_x_clr", 24'(X), 24'(8'h00));
      check("t2_flags_clr", 24'(FLAGS), 24'(4'b0000));

      // held clear acts once on its rising edge only
      send(3, 0);
      for (int k = 1; k <= 20; k++) begin
         if (k == 10) load_pkt(7, 0, 3'b000, 1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t3_x_held", 24'(X), 24'(8'h07));

      // packet and clear on the same CE
      load_pkt(-2, 0, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t4_x_same", 24'(X), 24'(8'hFE));
      check("t4_flags_same", 24'(FLAGS), 24'(4'b0001));

      // saturation at the negative accumulator limit, no wrap
      for (int k = 0; k < 2000; k++) send(-255, 0);
      step(1'b1, 1'b0, 1'b0);
      check("t5_x_pin", 24'(X), 24'(8'h00));
      check("t5_flags_pin", 24'(FLAGS), 24'(4'b0101));
      send(255, 0);
      step(1'b1, 1'b0, 1'b0);
      check("t5_flags_after", 24'(FLAGS), 24'(4'b0101));

      // PS/2 overflow bit forces full scale
      step(1'b1, 1'b1, 1'b0);
      load_pkt(3, 3, 3'b000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("ovf_force_x", 24'(X), 24'(8'hFF));
      check("ovf_force_y", 24'(Y), 24'(8'h03));

      // button map including START from the extension byte
      MOUSE     = {~MOUSE[24], 8'h00, 8'h00, 8'h0B};
      MOUSE_EXT = 16'h1000;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t6_buttons", 24'(BUTTONS), 24'(4'b1011));

`ifdef SATURN_MOUSE_SNAPSHOT_EN
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      load_pkt(9, 0, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("t6_frozen", 24'(X), 24'(8'h00));
      step(1'b1, 1'b0, 1'b0);
      check("t6_thawed", 24'(X), 24'(8'h09));
`endif

      // randomized traffic, gapped CE, clears and read windows
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic ra;
         ra = RESET_ACC;
         if ($urandom_range(0, 2) == 0)
            load_pkt(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                     3'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 9) == 0) ra = ~ra;
         step(1'($urandom), ra, ($urandom_range(0, 3) == 0));
      end

      // reset mid-traffic returns everything to idle
      load_pkt(50, 50, 3'b111, 1'b1, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      check("reset_idle", outs(), 24'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
